pool_stream_max: RTL and testbench

POOL_STREAM_MAX -- requirements
Module: pool_stream_max

---
 rtl/pool_stream_max.sv | 99 +++++++++
 tb/tb_pool_stream_max.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pool_stream_max.sv
// rtl/pool_stream_max.sv - multi-channel streaming max/min pooling over fixed-size windows
// Window result is registered once per WIN accepted beats and held under backpressure.
module pool_stream_max #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int WIN    = 4,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic                 flush,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           win_cnt
);
    localparam logic [7:0] LAST_CNT = 8'(WIN - 1);

    logic [CH*DATA_W-1:0] acc_q, acc_d;
    logic [CH*DATA_W-1:0] out_data_q, out_data_d;
    logic [CH*DATA_W-1:0] pooled;
    logic                 out_valid_q, out_valid_d;
    logic                 mode_q, mode_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 beat, first_beat, last_beat;

    // True when cand should replace cur for the given pooling direction.
    function automatic logic better(input logic [DATA_W-1:0] cand,
                                    input logic [DATA_W-1:0] cur,
                                    input logic              min_mode);
        logic gt, lt;
        if (SIGNED != 0) begin
            gt = $signed(cand) > $signed(cur);
            lt = $signed(cand) < $signed(cur);
        end else begin
            gt = cand > cur;
            lt = cand < cur;
        end
        return min_mode ? lt : gt;
    endfunction

    always_comb begin
        in_ready   = !out_valid_q || out_ready;
        beat       = in_valid && in_ready && !flush;
        first_beat = (cnt_q == 8'd0);
        last_beat  = beat && (cnt_q == LAST_CNT);

        pooled = acc_q;
        for (int k = 0; k < CH; k++) begin
            if (first_beat || better(in_data[k*DATA_W +: DATA_W],
                                     acc_q[k*DATA_W +: DATA_W], mode_q)) begin
                pooled[k*DATA_W +: DATA_W] = in_data[k*DATA_W +: DATA_W];
            end
        end

        acc_d  = beat ? pooled : acc_q;
        mode_d = (beat && first_beat) ? mode : mode_q;

        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 8'd0;
        end else if (beat) begin
            cnt_d = last_beat ? 8'd0 : cnt_q + 8'd1;
        end

        // A completing beat reloads the output even while the old result is being consumed.
        out_data_d  = last_beat ? pooled : out_data_q;
        out_valid_d = out_valid_q;
        if (last_beat) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            mode_q      <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign win_cnt   = cnt_q;
endmodule

// File: tb/tb_pool_stream_max.sv
// tb/tb_pool_stream_max.sv - scoreboard bench for pool_stream_max (signed 4-channel and unsigned 1-channel)
module tb_pool_stream_max;
    localparam int WIN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, mode = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [7:0]  win_cnt;
    logic        u_in_ready, u_out_valid;
    logic [7:0]  u_out_data, u_win_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] win_beats[$];
    logic        mode_w = 1'b0;
    logic [31:0] exp_s[$];
    logic [7:0]  exp_u[$];

    pool_stream_max #(.DATA_W(8), .CH(4), .WIN(WIN), .SIGNED(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .win_cnt(win_cnt)
    );

    pool_stream_max #(.DATA_W(8), .CH(1), .WIN(WIN), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid), .in_ready(u_in_ready),
        .mode(mode), .flush(flush), .out_data(u_out_data), .out_valid(u_out_valid),
        .out_ready(out_ready), .win_cnt(u_win_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: max or min over the collected window beats, per channel.
    function automatic logic [31:0] pool(input int chs, input bit sgn, input bit mn);
        logic [31:0] r;
        logic [31:0] w;
        logic [7:0]  b;
        int          best, v;
        r = '0;
        for (int k = 0; k < chs; k++) begin
            best = 0;
            for (int i = 0; i < win_beats.size(); i++) begin
                w = win_beats[i];
                b = w[k*8 +: 8];
                v = sgn ? int'($signed(b)) : int'(b);
                if (i == 0 || (mn ? (v < best) : (v > best))) best = v;
            end
            r[k*8 +: 8] = best[7:0];
        end
        return r;
    endfunction

    // Entered and left at posedge+1; drives one cycle of stimulus and updates the model.
    task automatic step(input logic v, input logic [31:0] d, input logic m,
                        input logic f, input logic r);
        logic        took;
        logic [31:0] es, eu;
        in_valid = v; in_data = d; mode = m; flush = f; out_ready = r;
        @(negedge clk);
        took = v && in_ready && !f;
        @(posedge clk);
        #1;
        if (f) begin
            win_beats.delete();
        end else if (took) begin
            if (win_beats.size() == 0) mode_w = m;
            win_beats.push_back(d);
            if (win_beats.size() == WIN) begin
                es = pool(4, 1'b1, mode_w);
                eu = pool(1, 1'b0, mode_w);
                exp_s.push_back(es);
                exp_u.push_back(eu[7:0]);
                chk("latency_valid", {31'b0, out_valid}, 32'd1);
                chk("latency_valid_u", {31'b0, u_out_valid}, 32'd1);
                win_beats.delete();
            end
        end
        chk("win_cnt", {24'b0, win_cnt}, win_beats.size());
        chk("win_cnt_u", {24'b0, u_win_cnt}, win_beats.size());
    endtask

    task automatic expect_out(input string name, input logic [31:0] es, input logic [7:0] eu);
        chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({name, "_data"}, out_data, es);
        chk({name, "_data_u"}, {24'b0, u_out_data}, {24'b0, eu});
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        in_valid = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_win_cnt"}, {24'b0, win_cnt}, 32'd0);
        chk({tag, "_u_out_valid"}, {31'b0, u_out_valid}, 32'd0);
        win_beats.delete();
        exp_s.delete();
        exp_u.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [31:0] prev_d = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", {31'b0, in_ready}, {31'b0, !out_valid || out_ready});
            if (prev_v && !prev_r) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_data", out_data, prev_d);
            end
            if (out_valid && out_ready) begin
                if (exp_s.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_s: output %h with no expected result", out_data);
                end else begin
                    chk("out_data", out_data, exp_s.pop_front());
                end
            end
            if (u_out_valid && out_ready) begin
                if (exp_u.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_u: output %h with no expected result", u_out_data);
                end else begin
                    chk("out_data_u", {24'b0, u_out_data}, {24'b0, exp_u.pop_front()});
                end
            end
        end
        prev_v = rst_n && out_valid;
        prev_r = out_ready;
        prev_d = out_data;
    end

    initial begin
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_win_cnt", {24'b0, win_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(1, 32'h80, 0, 0, 1); step(1, 32'hF0, 0, 0, 1);
        step(1, 32'h05, 0, 0, 1); step(1, 32'h7F, 0, 0, 1);
        expect_out("signed_max", 32'h0000007F, 8'hF0);
        for (int i = 0; i < 4; i++) step(1, 32'h80, 0, 0, 1);
        expect_out("signed_max_neg", 32'h00000080, 8'h80);

        step(1, 32'h10, 1, 0, 1); step(1, 32'hFF, 0, 0, 1);
        step(1, 32'h03, 0, 0, 1); step(1, 32'h20, 0, 0, 1);
        expect_out("min_mode", 32'h000000FF, 8'h03);

        step(1, 32'h01FF7F80, 0, 0, 1); step(1, 32'h0200807F, 1, 0, 1);
        step(1, 32'h00010101, 1, 0, 1); step(1, 32'h00000000, 0, 0, 1);
        expect_out("four_ch", 32'h02017F7F, 8'h80);

        step(1, 32'h7F, 0, 0, 1); step(1, 32'h7F, 0, 0, 1);
        step(1, 32'h7F7F7F7F, 0, 1, 1);
        chk("flush_win_cnt", {24'b0, win_cnt}, 32'd0);
        for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 0, 1);
        expect_out("after_flush", 32'h00000004, 8'h04);

        for (int i = 0; i < 12; i++) step(1, $urandom, 1'($urandom_range(0, 1)), 0, 1);
        for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0, 0);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 8, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
        end

        async_reset("rst_align");
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, 1);
        chk("pre_rst_win_cnt", {24'b0, win_cnt}, 32'd3);
        async_reset("rst_mid");
        for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0, 0);
        step(1, $urandom, 0, 0, 0);
        chk("pre_rst_pending", {31'b0, out_valid}, 32'd1);
        async_reset("rst_pending");

        step(1, 32'h05FB0A80, 0, 0, 1); step(1, 32'h0302F0FF, 1, 0, 1);
        step(1, 32'hFE017F01, 0, 0, 1); step(1, 32'h04000000, 1, 0, 1);
        expect_out("post_reset", 32'h05027F01, 8'hFF);

        for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0, 1);
        chk("drain_s", exp_s.size(), 32'd0);
        chk("drain_u", exp_u.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
